i_cache_nway: RTL and testbench

- Parametrised successor instruction cache: N-way set-associative, configurable set count and line length.
- Uses a ready/valid memory handshake in place of a fixed miss-cycle count.
- Adds flush (global invalidate), true-LRU replacement across any power-of-two way count, and a miss statistics counter.
- Sits between the IF stage PC and the line-wide instruction memory port.

---
 rtl/i_cache_nway.sv | 174 +++++++++++++++++
 tb/tb_i_cache_nway.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache_nway.sv
// i_cache_nway: N-way set-associative instruction cache with true-LRU, flush and ready/valid line fill
module i_cache_nway #(
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 2,
    parameter int WAYS       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            pc,
    input  logic                         fetch_req,
    output logic                         hit,
    output logic [WORD_W-1:0]            inst,
    output logic                         busy,
    output logic                         mem_read,
    output logic [WORD_W-1:0]            mem_addr,
    input  logic                         mem_ready,
    input  logic [WORD_W*LINE_WORDS-1:0] mem_data,
    input  logic                         flush,
    output logic [15:0]                  miss_count
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = WORD_W - IDX_W - OFF_W;
    localparam int AGE_W  = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int IW     = IDX_W > 0 ? IDX_W : 1;
    localparam int LINE_W = WORD_W * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t              state_q;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [AGE_W-1:0]    age_q   [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]   data_q  [SETS][WAYS];
    logic [LINE_W-1:0]   line_q;
    logic [TAG_W-1:0]    ftag_q;
    logic [IW-1:0]       fidx_q;
    logic                flush_pend_q;
    logic                mem_read_q;
    logic                busy_q;
    logic [WORD_W-1:0]   mem_addr_q;
    logic [15:0]         miss_q;

    logic [TAG_W-1:0]    tag;
    logic [IW-1:0]       idx;
    logic [OFF_W-1:0]    off;
    logic [WAYS-1:0]     match;
    logic [AGE_W-1:0]    hit_way;
    logic [AGE_W-1:0]    victim;
    logic [AGE_W-1:0]    touch_way;
    logic [IW-1:0]       touch_set;
    logic                touch_en;
    logic                idle;
    logic                miss;
    logic [LINE_W-1:0]   hit_line;
    logic [AGE_W-1:0]    age_d [WAYS];

    assign tag = pc[WORD_W-1 -: TAG_W];
    assign off = pc[OFF_W-1:0];

    generate
        if (IDX_W > 0) begin : g_idx
            assign idx = pc[OFF_W +: IW];
        end else begin : g_one_set
            assign idx = '0;
        end
    endgenerate

    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[idx][w] && tag_q[idx][w] == tag;
            if (match[w]) hit_way = AGE_W'(w);
        end
    end

    assign idle     = state_q == IDLE;
    assign hit      = fetch_req && idle && !flush && |match;
    assign miss     = fetch_req && idle && !flush && !(|match);
    assign hit_line = data_q[idx][hit_way];
    assign inst     = hit ? hit_line[(LINE_WORDS-1-int'(off))*WORD_W +: WORD_W] : '0;

    // Lowest invalid way wins over the LRU way, so scan it last in descending order
    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (age_q[fidx_q][w] == AGE_W'(WAYS-1)) victim = AGE_W'(w);
        for (int w = WAYS-1; w >= 0; w--)
            if (!valid_q[fidx_q][w]) victim = AGE_W'(w);
    end

    assign touch_en  = hit || state_q == FILL;
    assign touch_set = state_q == FILL ? fidx_q : idx;
    assign touch_way = state_q == FILL ? victim : hit_way;

    always_comb begin
        for (int w = 0; w < WAYS; w++)
            age_d[w] = AGE_W'(w) == touch_way ? '0 :
                       age_q[touch_set][w] < age_q[touch_set][touch_way] ? age_q[touch_set][w] + 1'b1 :
                       age_q[touch_set][w];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            mem_read_q   <= 1'b0;
            busy_q       <= 1'b0;
            mem_addr_q   <= '0;
            miss_q       <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            if (touch_en)
                for (int w = 0; w < WAYS; w++) age_q[touch_set][w] <= age_d[w];
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
                    end else if (miss) begin
                        state_q    <= REQ;
                        mem_read_q <= 1'b1;
                        busy_q     <= 1'b1;
                        mem_addr_q <= {pc[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
                        miss_q     <= miss_q + {15'b0, miss_q != 16'hFFFF};
                    end
                end
                REQ: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (mem_ready) begin
                        state_q    <= FILL;
                        mem_read_q <= 1'b0;
                        mem_addr_q <= '0;
                    end
                end
                FILL: begin
                    if (flush || flush_pend_q) begin
                        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
                    end else begin
                        valid_q[fidx_q][victim] <= 1'b1;
                    end
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    flush_pend_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            ftag_q <= tag;
            fidx_q <= idx;
        end
        if (state_q == REQ && mem_ready) line_q <= mem_data;
        if (state_q == FILL) begin
            tag_q[fidx_q][victim]  <= ftag_q;
            data_q[fidx_q][victim] <= line_q;
        end
    end

    always @(posedge clk)
        if (!reset && idle) assert ($onehot0(match));

    assign busy       = busy_q;
    assign mem_read   = mem_read_q;
    assign mem_addr   = mem_addr_q;
    assign miss_count = miss_q;
endmodule

// File: tb/tb_i_cache_nway.sv
// tb_i_cache_nway: directed vectors, corner sequences and a random run against an LRU-timestamp model
module tb_i_cache_nway;
    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  pc;
    logic         fetch_req;
    logic         hit;
    logic [15:0]  inst;
    logic         busy;
    logic         mem_read;
    logic [15:0]  mem_addr;
    logic         mem_ready;
    logic [63:0]  mem_data;
    logic         flush;
    logic [15:0]  miss_count;

    logic [15:0]  pc1;
    logic         fetch_req1;
    logic         hit1;
    logic [15:0]  inst1;
    logic         busy1;
    logic         mem_read1;
    logic [15:0]  mem_addr1;
    logic         mem_ready1;
    logic [127:0] mem_data1;
    logic         flush1;
    logic [15:0]  miss_count1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    i_cache_nway u0 (
        .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .hit(hit), .inst(inst),
        .busy(busy), .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_data(mem_data), .flush(flush), .miss_count(miss_count)
    );

    i_cache_nway #(.WORD_W(16), .LINE_WORDS(8), .SETS(4), .WAYS(4)) u1 (
        .clk(clk), .reset(reset), .pc(pc1), .fetch_req(fetch_req1), .hit(hit1), .inst(inst1),
        .busy(busy1), .mem_read(mem_read1), .mem_addr(mem_addr1), .mem_ready(mem_ready1),
        .mem_data(mem_data1), .flush(flush1), .miss_count(miss_count1)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {pc, fetch_req, mem_ready, mem_data, flush} = '0;
        {pc1, fetch_req1, mem_ready1, mem_data1, flush1} = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic miss0(input logic [15:0] a, input logic [63:0] d, input int wt);
        pc = a;
        fetch_req = 1'b1;
        @(negedge clk);
        chk("miss_detect_hit", hit, 1'b0);
        @(posedge clk);
        #1 fetch_req = 1'b0;
        chk("req_mem_read", mem_read, 1'b1);
        chk("req_mem_addr", mem_addr, a & 16'hFFFC);
        repeat (wt) @(posedge clk);
        #1 chk("req_held", mem_read, 1'b1);
        mem_ready = 1'b1;
        mem_data = d;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        chk("fill_busy", busy, 1'b1);
        chk("fill_mem_read", mem_read, 1'b0);
        @(posedge clk);
        #1 chk("idle_busy", busy, 1'b0);
    endtask

    task automatic miss1(input logic [15:0] a, input logic [127:0] d);
        pc1 = a;
        fetch_req1 = 1'b1;
        @(negedge clk);
        chk("sweep_miss_hit", hit1, 1'b0);
        @(posedge clk);
        #1 fetch_req1 = 1'b0;
        chk("sweep_mem_addr", mem_addr1, a & 16'hFFF8);
        mem_ready1 = 1'b1;
        mem_data1 = d;
        @(posedge clk);
        #1 mem_ready1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic hit1_chk(input logic [15:0] a, input logic eh, input logic [15:0] ei);
        pc1 = a;
        fetch_req1 = 1'b1;
        @(negedge clk);
        chk("sweep_hit", hit1, eh);
        chk("sweep_inst", inst1, ei);
        @(posedge clk);
        #1 fetch_req1 = 1'b0;
    endtask

    typedef struct {
        logic [15:0] pc;
        logic        exp_hit;
        logic [15:0] exp_inst;
    } vec_t;

    vec_t vt[8];

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pc = vt[i].pc;
            fetch_req = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_hit", i), hit, vt[i].exp_hit);
            chk($sformatf("vec%0d_inst", i), inst, vt[i].exp_inst);
            @(posedge clk);
            #1 fetch_req = 1'b0;
        end
    endtask

    // Reference model: line addresses per way, LRU by last-use timestamp
    bit          m_valid [2][2];
    int          m_line  [2][2];
    logic [63:0] m_data  [2][2];
    int          m_ts    [2][2];
    int          m_time, m_phase, m_addr, m_set, m_miss;
    bit          m_pend;
    logic [63:0] m_fill;

    function automatic int m_find(input int a);
        int s = (a >> 2) & 1;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_line[s][w] == (a & ~3)) return w;
        return -1;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0;
                m_ts[s][w] = -w;
            end
        m_time = 0;
        m_phase = 0;
        m_miss = 0;
        m_pend = 0;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
    endfunction

    function automatic void m_step();
        int w, v;
        if (m_phase == 0) begin
            if (flush) m_clear();
            else if (fetch_req) begin
                w = m_find(int'(pc));
                if (w >= 0) m_ts[(pc >> 2) & 1][w] = ++m_time;
                else begin
                    m_phase = 1;
                    m_addr = int'(pc) & ~3;
                    m_set = (int'(pc) >> 2) & 1;
                    if (m_miss < 65535) m_miss++;
                end
            end
        end else if (m_phase == 1) begin
            if (flush) m_pend = 1;
            if (mem_ready) begin
                m_fill = mem_data;
                m_phase = 2;
            end
        end else begin
            v = m_ts[m_set][0] < m_ts[m_set][1] ? 0 : 1;
            if (!m_valid[m_set][1]) v = 1;
            if (!m_valid[m_set][0]) v = 0;
            if (flush || m_pend) m_clear();
            else begin
                m_valid[m_set][v] = 1;
                m_line[m_set][v] = m_addr;
                m_data[m_set][v] = m_fill;
            end
            m_ts[m_set][v] = ++m_time;
            m_phase = 0;
            m_pend = 0;
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{16'h0004, 1'b1, 16'h1111};
        vt[1] = '{16'h0005, 1'b1, 16'h2222};
        vt[2] = '{16'h0006, 1'b1, 16'h3333};
        vt[3] = '{16'h0007, 1'b1, 16'h4444};
        vt[4] = '{16'h0001, 1'b1, 16'hA001};
        vt[5] = '{16'h0000, 1'b1, 16'hA000};
        vt[6] = '{16'h0011, 1'b1, 16'hC001};
        vt[7] = '{16'h0008, 1'b0, 16'h0000};

        do_reset();
        @(negedge clk);
        chk("rst_hit", hit, 1'b0);
        chk("rst_inst", inst, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_miss_count", miss_count, 16'h0);
        @(posedge clk);
        #1;

        // cold miss with three memory wait cycles
        miss0(16'h0005, 64'h1111_2222_3333_4444, 3);
        pc = 16'h0005;
        fetch_req = 1'b1;
        @(negedge clk);
        chk("cold_hit", hit, 1'b1);
        chk("cold_inst", inst, 16'h2222);
        chk("cold_miss_count", miss_count, 16'd1);
        @(posedge clk);
        #1 fetch_req = 1'b0;
        run_vec(0, 3);
        chk("sameline_miss_count", miss_count, 16'd1);

        // LRU eviction
        do_reset();
        miss0(16'h0000, 64'hA000_A001_A002_A003, 1);
        miss0(16'h0008, 64'hB000_B001_B002_B003, 0);
        run_vec(4, 4);
        miss0(16'h0010, 64'hC000_C001_C002_C003, 2);
        chk("lru_miss_count", miss_count, 16'd3);
        run_vec(5, 7);

        // flush during REQ
        do_reset();
        pc = 16'h0020;
        fetch_req = 1'b1;
        @(posedge clk);
        #1 fetch_req = 1'b0;
        chk("fl_req", mem_read, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        mem_ready = 1'b1;
        mem_data = 64'h5555_6666_7777_8888;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(posedge clk);
        #1 fetch_req = 1'b1;
        @(negedge clk);
        chk("fl_refetch_hit", hit, 1'b0);
        @(posedge clk);
        #1 fetch_req = 1'b0;
        chk("fl_miss_count", miss_count, 16'd2);
        chk("fl_refetch_req", mem_read, 1'b1);
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(posedge clk);
        #1 fetch_req = 1'b1;
        @(negedge clk);
        chk("fl_refill_hit", hit, 1'b1);
        chk("fl_refill_inst", inst, 16'h5555);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("fl_idle_hit", hit, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("fl_idle_no_miss", mem_read, 1'b0);
        @(negedge clk);
        chk("fl_idle_after", hit, 1'b0);
        @(posedge clk);
        #1 fetch_req = 1'b0;

        // asynchronous reset during REQ
        do_reset();
        miss0(16'h0004, 64'hD000_D001_D002_D003, 0);
        pc = 16'h0040;
        fetch_req = 1'b1;
        @(posedge clk);
        #1 chk("ar_req", mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("ar_mem_read", mem_read, 1'b0);
        chk("ar_hit", hit, 1'b0);
        chk("ar_miss_count", miss_count, 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ar_prior_pc_miss", hit, 1'b0);
        @(posedge clk);
        #1 fetch_req = 1'b0;

        // four-way sweep: five lines into set 0
        do_reset();
        miss1(16'h0000, 128'hA0A0_A1A1_A2A2_A3A3_A4A4_A5A5_A6A6_A7A7);
        miss1(16'h0020, 128'hB0B0_B1B1_B2B2_B3B3_B4B4_B5B5_B6B6_B7B7);
        miss1(16'h0040, 128'hC0C0_C1C1_C2C2_C3C3_C4C4_C5C5_C6C6_C7C7);
        miss1(16'h0060, 128'hD0D0_D1D1_D2D2_D3D3_D4D4_D5D5_D6D6_D7D7);
        miss1(16'h0080, 128'hE0E0_E1E1_E2E2_E3E3_E4E4_E5E5_E6E6_E7E7);
        hit1_chk(16'h0023, 1'b1, 16'hB3B3);
        hit1_chk(16'h0045, 1'b1, 16'hC5C5);
        hit1_chk(16'h0067, 1'b1, 16'hD7D7);
        hit1_chk(16'h0080, 1'b1, 16'hE0E0);
        hit1_chk(16'h0002, 1'b0, 16'h0000);
        chk("sweep_miss_count", miss_count1, 16'd6);

        // random traffic against the model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000 && n_fail < 50; c++) begin
            int w;
            logic eh;
            logic [15:0] ei;
            fetch_req = ($urandom % 4) != 0;
            pc = 16'($urandom_range(0, 31));
            mem_ready = ($urandom % 3) == 0;
            mem_data = {$urandom, $urandom};
            flush = ($urandom % 40) == 0;
            @(negedge clk);
            w = m_find(int'(pc));
            eh = fetch_req && m_phase == 0 && !flush && w >= 0;
            ei = eh ? 16'(m_data[(pc >> 2) & 1][w] >> ((3 - (pc & 3)) * 16)) : 16'h0;
            chk("rnd_hit", hit, eh);
            chk("rnd_inst", inst, ei);
            chk("rnd_busy", busy, m_phase != 0);
            chk("rnd_mem_read", mem_read, m_phase == 1);
            chk("rnd_mem_addr", mem_addr, m_phase == 1 ? 16'(m_addr) : 16'h0);
            chk("rnd_miss_count", miss_count, 16'(m_miss));
            @(posedge clk);
            m_step();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
